score_bcd_counter: RTL and testbench
====================================

# score_bcd_counter

Two-player score keeper for the Pong datapath. It accepts one-cycle point pulses from the ball/collision logic and holds each player's score as two BCD digits. It enforces a post-point lockout and detects the winning score. The four 4-bit digit outputs drive `hex_decoder` instances directly; the value 4'hF is the blank code those decoders render as all segments off.

## Interface
Parameters:
- `WIN_SCORE`, default 11: score that ends the game. Legal range 1..99.
- `HOLD_CYCLES`, default 50_000_000: lockout length in clocks after an accepted point. Must be ≥1.

Ports:
- `clk` input 1: system clock. The block uses this one clock only.
- `reset` input 1: synchronous, active-high reset.
- `point_p1` input 1: one-cycle pulse; player 1 scored.
- `point_p2` input 1: one-cycle pulse; player 2 scored.
- `clear` input 1: synchronous new-game request. Same effect as `reset`.
- `p1_ones`, `p1_tens` output 4: player 1 BCD digits, or blank code 4'hF.
- `p2_ones`, `p2_tens` output 4: player 2 BCD digits, or blank code 4'hF.
- `hold` output 1: high while in lockout.
- `game_over` output 1: high once either player reaches `WIN_SCORE`.
- `winner` output 1: 0 = player 1, 1 = player 2. Valid only while `game_over` is high.

## Operation
- FSM states: PLAY, HOLD, OVER. Reset and `clear` both force PLAY, zero both scores, zero the hold counter, and clear `game_over`, `winner` and `hold`.
- PLAY:
  - Exactly one point pulse high: that player's score increments by 1.
  - If the new score equals `WIN_SCORE`, go to OVER and set `winner`. Otherwise go to HOLD and load the counter with `HOLD_CYCLES-1`.
- Both pulses high in the same cycle: both are ignored, no score change, and the state stays PLAY.
- HOLD:
  - All point pulses are ignored.
  - The counter decrements each cycle. When it is 0, return to PLAY on the next edge.
  - The total time in HOLD is exactly `HOLD_CYCLES` clocks.
- OVER: all point pulses are ignored. The scores are frozen until `reset` or `clear`.
- BCD increment: ones digit 9 rolls to 0 and carries into tens. The score can never exceed `WIN_SCORE` (≤99), so the tens digit never overflows.
- `reset` or `clear` mid-HOLD or mid-OVER aborts immediately. No pending point survives.
- `clear` in the same cycle as a point pulse: `clear` wins and the scores become 0.

## Timing
- Point pulse sampled on edge N: digits, `hold`, `game_over` and `winner` all update on edge N (visible in cycle N+1).
- Every output is registered, or decoded only from registered state. There is no combinational path from any input to any output.
- Reset values:
  - Default build: all digits 4'd0, `hold` 0, `game_over` 0, `winner` 0.
  - With blanking enabled: tens digits reset to 4'hF instead.
- Minimum spacing between accepted points is `HOLD_CYCLES`+1 clocks.

## Configuration
- Macro: `SCORE_LEADING_ZERO_BLANK_EN`.
- Defined: each tens output reads 4'hF whenever that player's tens digit is 0, so scores 0–9 show a single digit. The ones digit is never blanked.
- Undefined: tens outputs always show the true BCD digit, so 0 displays as "00".
- Internal score state is identical in both builds. Only the output decode differs.

## Structure
- Package `score_pkg`:
  - FSM state enum (PLAY, HOLD, OVER).
  - Constant `BLANK_DIGIT` = 4'hF.
  - Constant `BCD_MAX_DIGIT` = 4'd9.
- Sub-module `bcd2_counter`:
  - Two-digit BCD register with a synchronous clear and an increment enable.
  - Outputs: ones, tens, and a combinational `at_value` compare against a 7-bit binary target.
  - Instantiated once per player.
- Top level: FSM, hold counter, point arbitration and the blanking decode.

## Test plan
- Reset, then 9 `point_p1` pulses with `HOLD_CYCLES`=4 spacing: p1 digits tens=0, ones=9. Blanking on: `p1_tens`=4'hF. Blanking off: `p1_tens`=0.
- One more `point_p1`: ones rolls 9→0 and tens becomes 1, seen on the next cycle. `hold` is high for exactly 4 cycles.
- Pulse `point_p2` on the 2nd cycle of HOLD: the score is unchanged and `hold` timing is unaffected.
- `point_p1` and `point_p2` together in PLAY: both scores unchanged and `hold` stays low.
- With `WIN_SCORE`=3, give player 2 three points: `game_over`=1 and `winner`=1 on the third accepted edge. Further pulses are ignored. Then `clear` returns all digits to reset values and `game_over`=0.
- Assert `reset` mid-HOLD alongside a `point_p1` pulse: all outputs return to reset values on that edge and the next accepted point needs no wait.

Source files
------------

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared FSM state type and digit constants for the score keeper
package score_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HOLD = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam logic [3:0] BLANK_DIGIT   = 4'hF;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // Tens digit as shown on the display when leading-zero blanking is active.
    function automatic logic [3:0] blank_leading_zero(input logic [3:0] tens);
        return (tens == 4'd0) ? BLANK_DIGIT : tens;
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD score register with clear, increment and value compare
module bcd2_counter
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    input  logic [6:0] target,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       at_value
);

    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [6:0] value_bin;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (clr) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (inc) begin
            if (ones_q == BCD_MAX_DIGIT) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        ones_q <= ones_d;
        tens_q <= tens_d;
    end

    assign value_bin = ({3'd0, tens_q} * 7'd10) + {3'd0, ones_q};
    assign at_value  = (value_bin == target);
    assign ones      = ones_q;
    assign tens      = tens_q;

endmodule

// File: rtl/score_bcd_counter.sv
// rtl/score_bcd_counter.sv - two-player BCD score keeper with post-point lockout and win detect
// Optional macro SCORE_LEADING_ZERO_BLANK_EN blanks a zero tens digit on the outputs.
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int WIN_SCORE   = 11,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       clear,
    output logic [3:0] p1_ones,
    output logic [3:0] p1_tens,
    output logic [3:0] p2_ones,
    output logic [3:0] p2_tens,
    output logic       hold,
    output logic       game_over,
    output logic       winner
);

    localparam int              CNT_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    // Compare against one below the win score so the win is known on the scoring edge.
    localparam logic [6:0]      WIN_TARGET = 7'(WIN_SCORE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             winner_q, winner_d;
    logic             new_game;
    logic             inc_p1, inc_p2;
    logic             p1_at_win, p2_at_win;
    logic [3:0]       p1_tens_raw, p2_tens_raw;

    assign new_game = reset | clear;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        inc_p1   = 1'b0;
        inc_p2   = 1'b0;
        case (state_q)
            PLAY: begin
                if (point_p1 ^ point_p2) begin
                    inc_p1 = point_p1;
                    inc_p2 = point_p2;
                    if ((point_p1 && p1_at_win) || (point_p2 && p2_at_win)) begin
                        state_d  = OVER;
                        winner_d = point_p2;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = PLAY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = PLAY;
            end
        endcase
        if (new_game) begin
            state_d  = PLAY;
            cnt_d    = '0;
            winner_d = 1'b0;
            inc_p1   = 1'b0;
            inc_p2   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PLAY;
            cnt_q    <= '0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
        end
    end

    bcd2_counter u_p1_score (
        .clk      (clk),
        .clr      (new_game),
        .inc      (inc_p1),
        .target   (WIN_TARGET),
        .ones     (p1_ones),
        .tens     (p1_tens_raw),
        .at_value (p1_at_win)
    );

    bcd2_counter u_p2_score (
        .clk      (clk),
        .clr      (new_game),
        .inc      (inc_p2),
        .target   (WIN_TARGET),
        .ones     (p2_ones),
        .tens     (p2_tens_raw),
        .at_value (p2_at_win)
    );

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    assign p1_tens = blank_leading_zero(p1_tens_raw);
    assign p2_tens = blank_leading_zero(p2_tens_raw);
`else
    assign p1_tens = p1_tens_raw;
    assign p2_tens = p2_tens_raw;
`endif

    assign hold      = (state_q == HOLD);
    assign game_over = (state_q == OVER);
    assign winner    = winner_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
// tb/tb_score_bcd_counter.sv - directed self-checking bench for score_bcd_counter
module tb_score_bcd_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic       clear = 1'b0;

    logic [3:0] a_p1_ones, a_p1_tens, a_p2_ones, a_p2_tens;
    logic       a_hold, a_game_over, a_winner;
    logic [3:0] b_p1_ones, b_p1_tens, b_p2_ones, b_p2_tens;
    logic       b_hold, b_game_over, b_winner;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    score_bcd_counter #(.WIN_SCORE(11), .HOLD_CYCLES(4)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .point_p1  (point_p1),
        .point_p2  (point_p2),
        .clear     (clear),
        .p1_ones   (a_p1_ones),
        .p1_tens   (a_p1_tens),
        .p2_ones   (a_p2_ones),
        .p2_tens   (a_p2_tens),
        .hold      (a_hold),
        .game_over (a_game_over),
        .winner    (a_winner)
    );

    score_bcd_counter #(.WIN_SCORE(3), .HOLD_CYCLES(4)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .point_p1  (point_p1),
        .point_p2  (point_p2),
        .clear     (clear),
        .p1_ones   (b_p1_ones),
        .p1_tens   (b_p1_tens),
        .p2_ones   (b_p2_ones),
        .p2_tens   (b_p2_tens),
        .hold      (b_hold),
        .game_over (b_game_over),
        .winner    (b_winner)
    );

    function automatic logic [3:0] exp_tens(input logic [3:0] t);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        return (t == 4'd0) ? 4'hF : t;
`else
        return t;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input logic p1, input logic p2);
        point_p1 = p1;
        point_p2 = p2;
        step();
        point_p1 = 1'b0;
        point_p2 = 1'b0;
    endtask

    initial begin
        wait_cycles(2);
        reset = 1'b0;
        check("reset_p1_ones", 32'(a_p1_ones), 32'd0);
        check("reset_p1_tens", 32'(a_p1_tens), 32'(exp_tens(4'd0)));
        check("reset_p2_ones", 32'(a_p2_ones), 32'd0);
        check("reset_p2_tens", 32'(a_p2_tens), 32'(exp_tens(4'd0)));
        check("reset_hold", 32'(a_hold), 32'd0);
        check("reset_game_over", 32'(a_game_over), 32'd0);
        check("reset_winner", 32'(a_winner), 32'd0);

        for (int i = 0; i < 9; i++) begin
            pulse(1'b1, 1'b0);
            check("p1_point_hold", 32'(a_hold), 32'd1);
            wait_cycles(4);
        end
        check("nine_p1_ones", 32'(a_p1_ones), 32'd9);
        check("nine_p1_tens", 32'(a_p1_tens), 32'(exp_tens(4'd0)));
        check("nine_hold_low", 32'(a_hold), 32'd0);

        pulse(1'b1, 1'b0);
        check("roll_p1_ones", 32'(a_p1_ones), 32'd0);
        check("roll_p1_tens", 32'(a_p1_tens), 32'd1);
        check("roll_hold_c1", 32'(a_hold), 32'd1);
        point_p2 = 1'b1;
        step();
        point_p2 = 1'b0;
        check("hold_c2", 32'(a_hold), 32'd1);
        check("hold_p2_ignored", 32'(a_p2_ones), 32'd0);
        step();
        check("hold_c3", 32'(a_hold), 32'd1);
        step();
        check("hold_c4", 32'(a_hold), 32'd1);
        step();
        check("hold_end", 32'(a_hold), 32'd0);
        check("hold_p2_still0", 32'(a_p2_ones), 32'd0);

        pulse(1'b1, 1'b1);
        check("both_hold", 32'(a_hold), 32'd0);
        check("both_p1_ones", 32'(a_p1_ones), 32'd0);
        check("both_p1_tens", 32'(a_p1_tens), 32'd1);
        check("both_p2_ones", 32'(a_p2_ones), 32'd0);
        pulse(1'b0, 1'b1);
        check("after_both_p2_ones", 32'(a_p2_ones), 32'd1);
        check("after_both_hold", 32'(a_hold), 32'd1);
        wait_cycles(4);

        check("b_over_p1", 32'(b_p1_ones), 32'd3);
        check("b_over_flag", 32'(b_game_over), 32'd1);
        check("b_over_winner_p1", 32'(b_winner), 32'd0);
        check("b_over_p2_frozen", 32'(b_p2_ones), 32'd0);

        clear = 1'b1;
        step();
        clear = 1'b0;
        check("b_clear_over", 32'(b_game_over), 32'd0);
        check("b_clear_p1_ones", 32'(b_p1_ones), 32'd0);
        check("b_clear_p1_tens", 32'(b_p1_tens), 32'(exp_tens(4'd0)));

        pulse(1'b0, 1'b1);
        wait_cycles(4);
        pulse(1'b0, 1'b1);
        check("b_two_p2", 32'(b_p2_ones), 32'd2);
        check("b_two_not_over", 32'(b_game_over), 32'd0);
        wait_cycles(4);
        pulse(1'b0, 1'b1);
        check("b_win_p2_ones", 32'(b_p2_ones), 32'd3);
        check("b_win_over", 32'(b_game_over), 32'd1);
        check("b_win_winner", 32'(b_winner), 32'd1);
        check("b_win_no_hold", 32'(b_hold), 32'd0);
        wait_cycles(2);
        pulse(1'b0, 1'b1);
        step();
        pulse(1'b1, 1'b0);
        check("b_frozen_p2", 32'(b_p2_ones), 32'd3);
        check("b_frozen_p1", 32'(b_p1_ones), 32'd0);
        check("b_frozen_over", 32'(b_game_over), 32'd1);

        clear = 1'b1;
        step();
        clear = 1'b0;
        check("b_clear2_p2_ones", 32'(b_p2_ones), 32'd0);
        check("b_clear2_p2_tens", 32'(b_p2_tens), 32'(exp_tens(4'd0)));
        check("b_clear2_over", 32'(b_game_over), 32'd0);
        check("b_clear2_winner", 32'(b_winner), 32'd0);

        clear = 1'b1;
        point_p1 = 1'b1;
        step();
        clear = 1'b0;
        point_p1 = 1'b0;
        check("clear_wins_p1", 32'(a_p1_ones), 32'd0);
        check("clear_wins_hold", 32'(a_hold), 32'd0);

        pulse(1'b1, 1'b0);
        check("pre_reset_p1", 32'(a_p1_ones), 32'd1);
        step();
        reset = 1'b1;
        point_p1 = 1'b1;
        step();
        reset = 1'b0;
        point_p1 = 1'b0;
        check("rst_hold_p1_ones", 32'(a_p1_ones), 32'd0);
        check("rst_hold_p1_tens", 32'(a_p1_tens), 32'(exp_tens(4'd0)));
        check("rst_hold_hold", 32'(a_hold), 32'd0);
        check("rst_hold_over", 32'(a_game_over), 32'd0);
        pulse(1'b1, 1'b0);
        check("rst_next_p1_ones", 32'(a_p1_ones), 32'd1);
        check("rst_next_hold", 32'(a_hold), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
